// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional feature macro: DMEM_ARB_PERF_EN (performance counters in dmem_arbiter).
package dmem_arb_pkg;

  // Which requester was granted most recently; the other side wins the next tie.
  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_e;

  // Arbiter state: idle/arbitrating, or inside a multi-beat loader burst.
  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } state_e;

  // Bytes per beat at the default 64-bit data width.
  localparam int BEAT_BYTES = 8;

endpackage

// File: rtl/dmem_arb_burst_ctr.sv
// Loader burst beat counter and address generator.
// 'load' executes beat 0 at load_addr and captures the burst; each 'step'
// executes the next beat at base + beat*bytes (wrapping mod 2^ADDR_W).
// 'last' flags the final beat of the burst in the current cycle.
module dmem_arb_burst_ctr #(
  parameter int ADDR_W  = 64,
  parameter int LEN_W   = 3,
  parameter int BEAT_SH = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  output logic [ADDR_W-1:0] beat_addr,
  output logic              last
);

  logic [ADDR_W-1:0] base_reg;
  logic [LEN_W-1:0]  beat_cnt_reg;
  logic [LEN_W-1:0]  rem_cnt_reg;

  // Capture burst parameters at beat 0, then advance one beat per step.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_reg     <= '0;
      beat_cnt_reg <= '0;
      rem_cnt_reg  <= '0;
    end else if (load) begin
      base_reg     <= load_addr;
      beat_cnt_reg <= LEN_W'(1);
      rem_cnt_reg  <= load_len;
    end else if (step) begin
      beat_cnt_reg <= beat_cnt_reg + LEN_W'(1);
      rem_cnt_reg  <= rem_cnt_reg - LEN_W'(1);
    end
  end

  // Beat 0 goes straight to the requested address; later beats use the stored base.
  always_comb begin
    beat_addr = base_reg + (ADDR_W'(beat_cnt_reg) << BEAT_SH);
    last      = (rem_cnt_reg == LEN_W'(1));
    if (load) begin
      beat_addr = load_addr;
      last      = (load_len == '0);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core load/store path and the debug/loader port.
// Round-robin between single-beat core accesses and loader bursts; the core is
// stalled while the loader owns memory.
// Optional feature macro: DMEM_ARB_PERF_EN adds saturating counters for core
// grants, loader beats and core stall cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = BEAT_BYTES * 8,
  parameter int MAX_BURST = 8
`ifdef DMEM_ARB_PERF_EN
  ,
  parameter int CNT_W     = 32
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         core_re,
  input  logic                         core_we,
  input  logic [ADDR_W-1:0]            core_addr,
  input  logic [DATA_W-1:0]            core_wdata,
  output logic [DATA_W-1:0]            core_rdata,
  output logic                         core_stall,
  input  logic                         dbg_req,
  input  logic                         dbg_we,
  input  logic [ADDR_W-1:0]            dbg_addr,
  input  logic [$clog2(MAX_BURST)-1:0] dbg_len,
  input  logic [DATA_W-1:0]            dbg_wdata,
  output logic                         dbg_gnt,
  output logic [DATA_W-1:0]            dbg_rdata,
  output logic                         dbg_rvalid,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic                         mem_we,
  output logic                         mem_re,
  input  logic [DATA_W-1:0]            mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]             perf_core_gnt,
  output logic [CNT_W-1:0]             perf_dbg_beats,
  output logic [CNT_W-1:0]             perf_stall
`endif
);

  localparam int LEN_W   = $clog2(MAX_BURST);
  localparam int BEAT_SH = $clog2(DATA_W / 8);

  state_e            state_reg, state_next;
  owner_e            last_gnt_reg, last_gnt_next;
  logic              burst_we_reg;
  logic              burst_we_cur;
  logic              dbg_rvalid_reg;
  logic [DATA_W-1:0] dbg_rdata_reg;

  logic              core_req;
  logic              core_gnt;
  logic              dbg_beat;
  logic              ctr_load;
  logic              ctr_step;
  logic [ADDR_W-1:0] beat_addr;
  logic              beat_last;

  assign core_req = core_re | core_we;

  dmem_arb_burst_ctr #(
    .ADDR_W  (ADDR_W),
    .LEN_W   (LEN_W),
    .BEAT_SH (BEAT_SH)
  ) u_burst_ctr (
    .clk       (clk),
    .reset     (reset),
    .load      (ctr_load),
    .step      (ctr_step),
    .load_addr (dbg_addr),
    .load_len  (dbg_len),
    .beat_addr (beat_addr),
    .last      (beat_last)
  );

  // Arbitration and burst sequencing; nothing is granted while reset is high.
  always_comb begin
    state_next    = state_reg;
    last_gnt_next = last_gnt_reg;
    core_gnt      = 1'b0;
    dbg_beat      = 1'b0;
    ctr_load      = 1'b0;
    ctr_step      = 1'b0;
    burst_we_cur  = burst_we_reg;
    if (!reset) begin
      unique case (state_reg)
        ARB: begin
          if (dbg_req && (!core_req || last_gnt_reg == OWN_CORE)) begin
            // Loader wins: beat 0 runs now with the freshly sampled direction.
            dbg_beat     = 1'b1;
            ctr_load     = 1'b1;
            burst_we_cur = dbg_we;
            if (beat_last) begin
              last_gnt_next = OWN_DBG;
            end else begin
              state_next = BURST;
            end
          end else if (core_req) begin
            core_gnt      = 1'b1;
            last_gnt_next = OWN_CORE;
          end
        end
        BURST: begin
          if (!dbg_req) begin
            // Loader abandoned the burst: no beat, hand memory back.
            state_next    = ARB;
            last_gnt_next = OWN_DBG;
          end else begin
            dbg_beat = 1'b1;
            ctr_step = 1'b1;
            if (beat_last) begin
              state_next    = ARB;
              last_gnt_next = OWN_DBG;
            end
          end
        end
        default: state_next = ARB;
      endcase
    end
  end

  // Memory-side mux; idle cycles park the address on the core path.
  always_comb begin
    mem_addr  = core_addr;
    mem_wdata = core_wdata;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (dbg_beat) begin
      mem_addr  = beat_addr;
      mem_wdata = dbg_wdata;
      mem_we    = burst_we_cur;
      mem_re    = ~burst_we_cur;
    end else if (core_gnt) begin
      mem_we = core_we;
      mem_re = core_re & ~core_we;
    end
  end

  assign core_stall = core_req & ~core_gnt;
  assign core_rdata = mem_rdata;
  assign dbg_gnt    = dbg_beat;
  assign dbg_rdata  = dbg_rdata_reg;
  assign dbg_rvalid = dbg_rvalid_reg;

  // FSM state, fairness owner and burst direction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ARB;
      last_gnt_reg <= OWN_DBG;
      burst_we_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      last_gnt_reg <= last_gnt_next;
      if (ctr_load) begin
        burst_we_reg <= dbg_we;
      end
    end
  end

  // Loader read data is registered and presented the cycle after its beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_rvalid_reg <= 1'b0;
      dbg_rdata_reg  <= '0;
    end else begin
      dbg_rvalid_reg <= dbg_beat & ~burst_we_cur;
      if (dbg_beat && !burst_we_cur) begin
        dbg_rdata_reg <= mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [2:0] perf_inc;
  assign perf_inc = {core_stall, dbg_beat, core_gnt};

  for (genvar gi = 0; gi < 3; gi++) begin : g_perf
    logic [CNT_W-1:0] cnt_reg;
    // Saturating event counter, cleared by reset.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_reg <= '0;
      end else if (perf_inc[gi] && cnt_reg != '1) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign perf_core_gnt  = g_perf[0].cnt_reg;
  assign perf_dbg_beats = g_perf[1].cnt_reg;
  assign perf_stall     = g_perf[2].cnt_reg;
`endif

endmodule
